// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : npc_pkg
//  Purpose : Shared encodings and helpers for the next-PC / PC-register stage.
//            - br_op (3b) / j_op (2b) decode encodings
//            - default reset PC
//            - branch condition helper
//  Revision: 1.0  initial release
// ============================================================================
package npc_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6
  } br_op_e;

  // Encoding 3 is reserved and decodes as "no jump".
  typedef enum logic [1:0] {
    J_NONE = 2'd0,
    J_J    = 2'd1,
    J_JR   = 2'd2
  } j_op_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Branch condition from the ID-stage comparator flags.
  function automatic logic br_cond(input logic [2:0] op,
                                   input logic       zero,
                                   input logic       lt0,
                                   input logic       bg0);
    logic c;
    c = 1'b0;
    case (op)
      BR_BEQ:  c = zero;
      BR_BNE:  c = ~zero;
      BR_BLEZ: c = ~bg0;
      BR_BGTZ: c = bg0;
      BR_BLTZ: c = lt0;
      BR_BGEZ: c = ~lt0;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/npc_calc.sv
`default_nettype none
// ============================================================================
//  Module  : npc_calc
//  Purpose : Combinational branch resolution for the instruction in ID.
//            Computes the branch condition, taken/redirect qualifiers, the
//            redirect target and the JR misalignment flag.
//  Ports   : in  id_valid, stall, br_op[2:0], j_op[1:0], cmp_zero/lt0/bg0,
//                id_pc[31:0], id_imm16[15:0], id_index26[25:0], id_rs[31:0]
//            out br_taken, redirect, target[31:0], misalign
//  Revision: 1.0  initial release
// ============================================================================
module npc_calc
  import npc_pkg::*;
(
  input  logic        id_valid,
  input  logic        stall,
  input  logic [2:0]  br_op,
  input  logic [1:0]  j_op,
  input  logic        cmp_zero,
  input  logic        cmp_lt0,
  input  logic        cmp_bg0,
  input  logic [31:0] id_pc,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_index26,
  input  logic [31:0] id_rs,
  output logic        br_taken,
  output logic        redirect,
  output logic [31:0] target,
  output logic        misalign
);

  logic        w_cond;
  logic        w_is_j;
  logic        w_is_jr;
  logic [31:0] w_id_pc_plus4;
  logic [31:0] w_br_off;

  assign w_cond        = br_cond(br_op, cmp_zero, cmp_lt0, cmp_bg0);
  assign w_is_j        = (j_op == J_J);
  assign w_is_jr       = (j_op == J_JR);
  assign w_id_pc_plus4 = id_pc + 32'd4;
  assign w_br_off      = {{14{id_imm16[15]}}, id_imm16, 2'b00};

  assign br_taken = id_valid & w_cond & ~stall;
  assign redirect = id_valid & ~stall & (br_taken | w_is_j | w_is_jr);

  // Jumps override branches when both are decoded (illegal combination).
  always_comb begin
    target = w_id_pc_plus4 + w_br_off;
    if (w_is_j) begin
      target = {w_id_pc_plus4[31:28], id_index26, 2'b00};
    end else if (w_is_jr) begin
      // Low bits are dropped; the misalign flag reports the event instead.
      target = {id_rs[31:2], 2'b00};
    end
  end

  assign misalign = redirect & w_is_jr & (id_rs[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: rtl/npc_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module  : npc_pc_unit
//  Purpose : Next-PC / PC-register stage of the 5-stage MIPS pipeline.
//            Branches and jumps resolve in ID with one delay slot; the slot
//            instruction already in IF is never squashed.
//  Config  : BRANCH_STATS_EN - adds saturating counters stat_br, stat_taken,
//            stat_jump (CNT_W bits each).
//  Ports   : in  clk, reset (sync, active-high), stall, id_valid, br_op[2:0],
//                j_op[1:0], cmp_zero, cmp_lt0, cmp_bg0, id_pc[31:0],
//                id_imm16[15:0], id_index26[25:0], id_rs[31:0]
//            out pc[31:0] (registered), pc_plus4[31:0], redirect, br_taken,
//                pc_misalign (registered pulse)
//  Revision: 1.0  initial release
// ============================================================================
module npc_pc_unit
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             id_valid,
  input  logic [2:0]       br_op,
  input  logic [1:0]       j_op,
  input  logic             cmp_zero,
  input  logic             cmp_lt0,
  input  logic             cmp_bg0,
  input  logic [31:0]      id_pc,
  input  logic [15:0]      id_imm16,
  input  logic [25:0]      id_index26,
  input  logic [31:0]      id_rs,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             redirect,
  output logic             br_taken,
  output logic             pc_misalign
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_br,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_jump
`endif
);

  logic [31:0] r_pc;
  logic        r_misalign;
  logic        w_br_taken;
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_misalign;

  npc_calc u_calc (
    .id_valid   (id_valid),
    .stall      (stall),
    .br_op      (br_op),
    .j_op       (j_op),
    .cmp_zero   (cmp_zero),
    .cmp_lt0    (cmp_lt0),
    .cmp_bg0    (cmp_bg0),
    .id_pc      (id_pc),
    .id_imm16   (id_imm16),
    .id_index26 (id_index26),
    .id_rs      (id_rs),
    .br_taken   (w_br_taken),
    .redirect   (w_redirect),
    .target     (w_target),
    .misalign   (w_misalign)
  );

  assign pc          = r_pc;
  assign pc_plus4    = r_pc + 32'd4;
  assign pc_misalign = r_misalign;
  // Reset masks the qualifiers so no redirect is reported across reset.
  assign br_taken    = w_br_taken & ~reset;
  assign redirect    = w_redirect & ~reset;

  // Stall suppresses w_redirect inside npc_calc, so a held branch simply
  // re-evaluates with the current flags once the stall drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else if (stall) begin
      r_misalign <= 1'b0;
    end else if (w_redirect) begin
      r_pc       <= w_target;
      r_misalign <= w_misalign;
    end else begin
      r_pc       <= pc_plus4;
      r_misalign <= 1'b0;
    end
  end

`ifdef BRANCH_STATS_EN
  logic r_unused_none;
  logic w_ev_br;
  logic w_ev_taken;
  logic w_ev_jump;
  logic [CNT_W-1:0] r_stat_br;
  logic [CNT_W-1:0] r_stat_taken;
  logic [CNT_W-1:0] r_stat_jump;

  assign w_ev_br    = id_valid & ~stall & (br_op != BR_NONE);
  assign w_ev_taken = w_br_taken;
  assign w_ev_jump  = id_valid & ~stall & ((j_op == J_J) | (j_op == J_JR));

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_br    <= '0;
      r_stat_taken <= '0;
      r_stat_jump  <= '0;
    end else begin
      if (w_ev_br && !(&r_stat_br))
        r_stat_br <= r_stat_br + CNT_W'(1);
      if (w_ev_taken && !(&r_stat_taken))
        r_stat_taken <= r_stat_taken + CNT_W'(1);
      if (w_ev_jump && !(&r_stat_jump))
        r_stat_jump <= r_stat_jump + CNT_W'(1);
    end
  end

  assign stat_br    = r_stat_br;
  assign stat_taken = r_stat_taken;
  assign stat_jump  = r_stat_jump;
`else
  // Keeps CNT_W referenced in builds without the counters.
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_npc_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module  : tb_npc_pc_unit
//  Purpose : Directed self-checking bench for npc_pc_unit. Define
//            BRANCH_STATS_EN to also cover the statistics counters.
//  Revision: 1.0  initial release
// ============================================================================
module tb_npc_pc_unit;
  import npc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        id_valid;
  logic [2:0]  br_op;
  logic [1:0]  j_op;
  logic        cmp_zero;
  logic        cmp_lt0;
  logic        cmp_bg0;
  logic [31:0] id_pc;
  logic [15:0] id_imm16;
  logic [25:0] id_index26;
  logic [31:0] id_rs;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        br_taken;
  logic        pc_misalign;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br;
  logic [31:0] stat_taken;
  logic [31:0] stat_jump;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  npc_pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .id_valid    (id_valid),
    .br_op       (br_op),
    .j_op        (j_op),
    .cmp_zero    (cmp_zero),
    .cmp_lt0     (cmp_lt0),
    .cmp_bg0     (cmp_bg0),
    .id_pc       (id_pc),
    .id_imm16    (id_imm16),
    .id_index26  (id_index26),
    .id_rs       (id_rs),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .redirect    (redirect),
    .br_taken    (br_taken),
    .pc_misalign (pc_misalign)
`ifdef BRANCH_STATS_EN
    ,
    .stat_br     (stat_br),
    .stat_taken  (stat_taken),
    .stat_jump   (stat_jump)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid   = 1'b0;
    br_op      = BR_NONE;
    j_op       = J_NONE;
    cmp_zero   = 1'b0;
    cmp_lt0    = 1'b0;
    cmp_bg0    = 1'b0;
    id_pc      = 32'h0;
    id_imm16   = 16'h0;
    id_index26 = 26'h0;
    id_rs      = 32'h0;
  endtask

  // {br_op[2:0], cmp_zero, cmp_lt0, cmp_bg0, expected br_taken}
  logic [6:0]  tbl [10];
  logic [31:0] exp_pc;
  logic [31:0] held_pc;

  initial begin
    tbl = '{ {3'd1, 3'b000, 1'b0},   // BEQ  not equal
             {3'd2, 3'b000, 1'b1},   // BNE  not equal
             {3'd2, 3'b100, 1'b0},   // BNE  equal
             {3'd3, 3'b000, 1'b1},   // BLEZ rs <= 0
             {3'd3, 3'b001, 1'b0},   // BLEZ rs > 0
             {3'd4, 3'b001, 1'b1},   // BGTZ rs > 0
             {3'd4, 3'b010, 1'b0},   // BGTZ rs < 0
             {3'd5, 3'b010, 1'b1},   // BLTZ rs < 0
             {3'd6, 3'b010, 1'b0},   // BGEZ rs < 0
             {3'd0, 3'b111, 1'b0} }; // NONE

    // Reset with a jump in ID: redirect must stay masked.
    clear_id();
    stall    = 1'b0;
    reset    = 1'b1;
    id_valid = 1'b1;
    j_op     = J_J;
    step();
    step();
    check("reset_pc", pc, 32'h0000_3000);
    check("reset_misalign", {31'b0, pc_misalign}, 32'd0);
    check("reset_redirect", {31'b0, redirect}, 32'd0);
    check("reset_br_taken", {31'b0, br_taken}, 32'd0);
`ifdef BRANCH_STATS_EN
    check("reset_stat_jump", stat_jump, 32'd0);
`endif
    reset = 1'b0;
    clear_id();
    #1;
    check("pc_plus4_comb", pc_plus4, 32'h0000_3004);

    // Free-running sequence.
    step();
    check("free_pc_1", pc, 32'h0000_3004);
    check("free_redirect_1", {31'b0, redirect}, 32'd0);
    step();
    check("free_pc_2", pc, 32'h0000_3008);
    step();
    check("free_pc_3", pc, 32'h0000_300C);
    check("free_redirect_3", {31'b0, redirect}, 32'd0);

    // Bubble carrying a jump must not redirect.
    j_op = J_J;
    #1;
    check("bubble_redirect", {31'b0, redirect}, 32'd0);
    clear_id();

    // BEQ taken: 0x3004 + 4 + (4 << 2) = 0x3018.
    id_valid = 1'b1; br_op = BR_BEQ; id_pc = 32'h0000_3004;
    id_imm16 = 16'h0004; cmp_zero = 1'b1;
    #1;
    check("beq_br_taken", {31'b0, br_taken}, 32'd1);
    check("beq_redirect", {31'b0, redirect}, 32'd1);
    step();
    check("beq_pc", pc, 32'h0000_3018);

    // Same branch, not taken.
    cmp_zero = 1'b0;
    #1;
    check("beq_nt_br_taken", {31'b0, br_taken}, 32'd0);
    check("beq_nt_redirect", {31'b0, redirect}, 32'd0);
    step();
    check("beq_nt_pc", pc, 32'h0000_301C);

    // BGEZ backward: 0x3010 + 4 - 4 = 0x3010.
    br_op = BR_BGEZ; id_pc = 32'h0000_3010; id_imm16 = 16'hFFFF;
    cmp_lt0 = 1'b0;
    #1;
    check("bgez_br_taken", {31'b0, br_taken}, 32'd1);
    step();
    check("bgez_pc", pc, 32'h0000_3010);

    // Condition table; a taken branch lands on 0x5000 + 4.
    exp_pc = 32'h0000_3010;
    for (int i = 0; i < 10; i++) begin
      clear_id();
      id_valid = 1'b1;
      id_pc    = 32'h0000_5000;
      br_op    = tbl[i][6:4];
      cmp_zero = tbl[i][3];
      cmp_lt0  = tbl[i][2];
      cmp_bg0  = tbl[i][1];
      #1;
      check($sformatf("cond_%0d_taken", i), {31'b0, br_taken}, {31'b0, tbl[i][0]});
      step();
      exp_pc = tbl[i][0] ? 32'h0000_5004 : exp_pc + 32'd4;
      check($sformatf("cond_%0d_pc", i), pc, exp_pc);
    end

    // BNE taken held by a 2-cycle stall: 0x3020 + 4 + 0x20 = 0x3044.
    clear_id();
    id_valid = 1'b1; br_op = BR_BNE; id_pc = 32'h0000_3020;
    id_imm16 = 16'h0008; cmp_zero = 1'b0; stall = 1'b1;
    held_pc = exp_pc;
    #1;
    check("stall_redirect", {31'b0, redirect}, 32'd0);
    check("stall_br_taken", {31'b0, br_taken}, 32'd0);
    step();
    check("stall_pc_1", pc, held_pc);
    cmp_zero = 1'b1;  // flags may change while held
    step();
    check("stall_pc_2", pc, held_pc);
    cmp_zero = 1'b0;
    stall    = 1'b0;
    #1;
    check("unstall_redirect", {31'b0, redirect}, 32'd1);
    step();
    check("unstall_pc", pc, 32'h0000_3044);

    // Reset during a stalled taken branch.
    stall = 1'b1;
    reset = 1'b1;
    step();
    check("reset_mid_stall_pc", pc, 32'h0000_3000);
    check("reset_mid_stall_redirect", {31'b0, redirect}, 32'd0);
    reset = 1'b0;
    stall = 1'b0;
    clear_id();

    // Misaligned JR.
    id_valid = 1'b1; j_op = J_JR; id_rs = 32'h0000_4002;
    #1;
    check("jr_redirect", {31'b0, redirect}, 32'd1);
    check("jr_br_taken", {31'b0, br_taken}, 32'd0);
    step();
    check("jr_pc", pc, 32'h0000_4000);
    check("jr_misalign", {31'b0, pc_misalign}, 32'd1);
`ifdef BRANCH_STATS_EN
    check("jr_stat_jump", stat_jump, 32'd1);
    check("jr_stat_br", stat_br, 32'd0);
`endif

    // J crossing a 256 MB region: id_pc + 4 = 0x4000_0000.
    clear_id();
    id_valid = 1'b1; j_op = J_J; id_pc = 32'h3FFF_FFFC; id_index26 = 26'h000_0010;
    step();
    check("j_pc", pc, 32'h4000_0040);
    check("j_misalign", {31'b0, pc_misalign}, 32'd0);

    // Aligned JR: no misalign pulse.
    clear_id();
    id_valid = 1'b1; j_op = J_JR; id_rs = 32'h0000_8000;
    step();
    check("jr_aligned_pc", pc, 32'h0000_8000);
    check("jr_aligned_misalign", {31'b0, pc_misalign}, 32'd0);

    // Branch to the top of memory, then silent wrap to zero.
    clear_id();
    id_valid = 1'b1; br_op = BR_BEQ; cmp_zero = 1'b1; id_pc = 32'hFFFF_FFF8;
    step();
    check("wrap_target_pc", pc, 32'hFFFF_FFFC);
    clear_id();
    step();
    check("wrap_pc", pc, 32'h0000_0000);
`ifdef BRANCH_STATS_EN
    check("end_stat_br", stat_br, 32'd1);
    check("end_stat_taken", stat_taken, 32'd1);
    check("end_stat_jump", stat_jump, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
